// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-memory access with byte-lane
// steering, load sign/zero extension, access checks and an ack timeout.
module load_store_unit #(
   parameter int MAX_WAIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int NUM_LANES = 4;
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;

   logic        rsp_valid_d, rsp_err_d, busy_d;
   logic [31:0] rsp_rdata_d;
   logic        mem_req_d, mem_we_d;
   logic [31:0] mem_addr_d, mem_wdata_d;
   logic [3:0]  mem_be_d;

   logic                            accept, bad;
   logic [NUM_LANES-1:0]            lane_be;
   logic [NUM_LANES-1:0][7:0]       lane_wbyte;
   logic [31:0]                     rd_shift, load_fmt;

   assign req_ready = rst & (state_q == IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      bad = 1'b0;
      case (req_funct3)
         3'b000:         bad = 1'b0;
         3'b001:         bad = req_addr[0];
         3'b010:         bad = (req_addr[1:0] != 2'b00);
         3'b100:         bad = req_we;
         3'b101:         bad = req_we | req_addr[0];
         default:        bad = 1'b1;
      endcase
   end

   // Per-lane byte enable and store byte; misaligned cases never reach
   // ACCESS, so halfword lanes only need addr[1].
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      always_comb begin
         lane_be[i]    = 1'b1;
         lane_wbyte[i] = req_wdata[8*i +: 8];
         case (req_funct3[1:0])
            2'b00: begin
               lane_be[i]    = (req_addr[1:0] == LANE);
               lane_wbyte[i] = req_wdata[7:0];
            end
            2'b01: begin
               lane_be[i]    = (req_addr[1] == LANE[1]);
               lane_wbyte[i] = req_wdata[8*(i%2) +: 8];
            end
            default: begin
               lane_be[i]    = 1'b1;
               lane_wbyte[i] = req_wdata[8*i +: 8];
            end
         endcase
      end
   end

   assign rd_shift = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  load_fmt = {24'b0, rd_shift[7:0]};
         3'b001:  load_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b101:  load_fmt = {16'b0, rd_shift[15:0]};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'b0;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_be_d    = mem_be;
      mem_wdata_d = mem_wdata;
      case (state_q)
         IDLE: begin
            if (accept) begin
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               if (bad) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = ACCESS;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = lane_be;
                  mem_wdata_d = lane_wbyte;
               end
            end
         end
         ACCESS: begin
            // Ack in the final wait cycle still completes the access.
            if (mem_ack || cnt_q == LAST_WAIT) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = ~mem_ack;
               rsp_rdata_d = (mem_ack && !mem_we) ? load_fmt : 32'b0;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = 32'b0;
               mem_be_d    = 4'b0;
               mem_wdata_d = 32'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         funct3_q  <= 3'b0;
         off_q     <= 2'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'b0;
         busy      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'b0;
         mem_be    <= 4'b0;
         mem_wdata <= 32'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         funct3_q  <= funct3_d;
         off_q     <= off_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_rdata <= rsp_rdata_d;
         busy      <= busy_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_be    <= mem_be_d;
         mem_wdata <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: formatting, errors, timeout, reset, back-to-back.
module tb_load_store_unit;

   logic        clk = 1'b0, rst = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
   logic        req_ready, rsp_valid, rsp_err, busy, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", req_ready); end
      checks++; if ({busy, mem_req, rsp_valid, mem_be} !== 7'b0) begin errors++;
         $display("FAIL rst_outs got %b exp 0", {busy, mem_req, rsp_valid, mem_be}); end
      checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 96'b0) begin errors++;
         $display("FAIL rst_data got %h exp 0", {mem_addr, mem_wdata, rsp_rdata}); end
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %0b exp 1", req_ready); end
   endtask

   // LB 0x103, ack after one cycle; also the first acceptance after reset release.
   task automatic test_lb;
      drive(1'b0, 3'b000, 32'h103, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++;
         $display("FAIL lb_req got req=%0b we=%0b exp 1 0", mem_req, mem_we); end
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 100", mem_addr); end
      checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", mem_be); end
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
         $display("FAIL lb_busy got %b exp 100", {busy, req_ready, rsp_valid}); end
      mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++;
         $display("FAIL lb_rsp got v=%0b e=%0b exp 1 0", rsp_valid, rsp_err); end
      checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", rsp_rdata); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop got %0b exp 0", mem_req); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++;
         $display("FAIL lb_idle got %b exp 010", {rsp_valid, req_ready, busy}); end
   endtask

   task automatic test_sh;
      drive(1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL sh_addr got %h exp 20", mem_addr); end
      checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", mem_be); end
      checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", mem_wdata); end
      checks++; if (mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++;
         $display("FAIL sh_we got we=%0b req=%0b exp 1 1", mem_we, mem_req); end
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++;
         $display("FAIL sh_rsp got v=%0b e=%0b d=%h exp 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_errors;
      logic [2:0]  f3 [3] = '{3'b010, 3'b101, 3'b011};
      logic        we [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] ad [3] = '{32'h6, 32'h0, 32'h8};
      for (int i = 0; i < 3; i++) begin
         drive(we[i], f3[i], ad[i], 32'h1234_5678);
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++;
            $display("FAIL err%0d_rsp got v=%0b e=%0b d=%h exp 1 1 0", i, rsp_valid, rsp_err, rsp_rdata); end
         checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL err%0d_mem got req=%0b busy=%0b exp 0 1", i, mem_req, busy); end
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
            $display("FAIL err%0d_idle got v=%0b rdy=%0b exp 0 1", i, rsp_valid, req_ready); end
      end
   endtask

   // MAX_WAIT=4: no ack gives 4 request cycles and an error; ack in cycle 4 wins.
   task automatic test_timeout;
      for (int pass = 0; pass < 2; pass++) begin
         int req_cycles = 0;
         int rsp_seen = 0;
         logic err_seen = 1'b0;
         logic [31:0] data_seen = 32'h0;
         drive(1'b0, 3'b010, 32'h40, 32'h0);
         @(negedge clk);
         req_valid = 1'b0;
         for (int c = 0; c < 8; c++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (rsp_valid === 1'b1) begin rsp_seen++; err_seen = rsp_err; data_seen = rsp_rdata; end
            mem_ack = (pass == 1 && req_cycles == 4 && mem_req === 1'b1);
            mem_rdata = 32'h1234_5678;
            @(negedge clk);
         end
         mem_ack = 1'b0;
         checks++; if (req_cycles != 4) begin errors++; $display("FAIL to%0d_cycles got %0d exp 4", pass, req_cycles); end
         checks++; if (rsp_seen != 1) begin errors++; $display("FAIL to%0d_rsp_count got %0d exp 1", pass, rsp_seen); end
         checks++; if (err_seen !== (pass == 0)) begin errors++; $display("FAIL to%0d_err got %0b exp %0b", pass, err_seen, pass == 0); end
         checks++; if (data_seen !== (pass == 0 ? 32'h0 : 32'h1234_5678)) begin errors++;
            $display("FAIL to%0d_rdata got %h", pass, data_seen); end
      end
   endtask

   task automatic test_reset_mid_access;
      drive(1'b0, 3'b010, 32'h80, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %0b exp 1", mem_req); end
      #2 rst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin errors++;
         $display("FAIL mid_async got req=%0b busy=%0b rdy=%0b exp 0 0 0", mem_req, busy, req_ready); end
      #1 rst = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL late_ack%0d got v=%0b busy=%0b exp 0 0", c, rsp_valid, busy); end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_back_to_back;
      drive(1'b0, 3'b101, 32'h2, 32'h0);
      @(negedge clk);
      drive(1'b1, 3'b000, 32'h1, 32'h0000_00A5);
      checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL b2b_lhu_be got %b exp 1100", mem_be); end
      mem_ack = 1'b1; mem_rdata = 32'h8765_4321;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_8765 || req_ready !== 1'b0) begin errors++;
         $display("FAIL b2b_lhu_rsp got v=%0b d=%h rdy=%0b exp 1 00008765 0", rsp_valid, rsp_rdata, req_ready); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin errors++;
         $display("FAIL b2b_gap got rdy=%0b req=%0b exp 1 0", req_ready, mem_req); end
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010) begin errors++;
         $display("FAIL b2b_sb_req got req=%0b we=%0b be=%b exp 1 1 0010", mem_req, mem_we, mem_be); end
      checks++; if (mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h0) begin errors++;
         $display("FAIL b2b_sb_data got %h @%h exp a5a5a5a5 @0", mem_wdata, mem_addr); end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++;
         $display("FAIL b2b_sb_rsp got v=%0b e=%0b d=%h exp 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_lb;
      test_sh;
      test_errors;
      test_timeout;
      test_reset_mid_access;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
